// File: rtl/jtdd_sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM read-port arbiter.
package jtdd_sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam int unsigned AW_DEF = 22;
    localparam int unsigned DW_DEF = 32;

    // Index width able to address SLOTS entries (at least one bit).
    function automatic int unsigned idx_width(input int unsigned slots);
        return (slots > 1) ? $clog2(slots) : 1;
    endfunction

endpackage

// File: rtl/jtdd_rr_pick.sv
// Combinational round-robin picker: first set pend bit at or after ptr, wrapping.
module jtdd_rr_pick
    import jtdd_sdram_arb_pkg::*;
#(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned PW    = idx_width(SLOTS)
) (
    input  logic [SLOTS-1:0] pend,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    gnt,
    output logic             any
);

    logic [PW-1:0] idx;

    // Walk the offsets from farthest to nearest so the nearest pending slot wins.
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            idx = PW'((32'(ptr) + 32'(i)) % SLOTS);
            if (pend[idx]) begin
                gnt = idx;
            end
        end
    end

    assign any = |pend;

endmodule

// File: rtl/jtdd_sdram_arb.sv
// SDRAM read-port arbiter: per-slot one-word caches filled through a
// round-robin req/ack/rdy handshake with the SDRAM controller.
module jtdd_sdram_arb
    import jtdd_sdram_arb_pkg::*;
#(
    parameter int unsigned SLOTS = 4,
    parameter int unsigned AW    = AW_DEF,
    parameter int unsigned DW    = DW_DEF
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                downloading,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                busy
);

    localparam int unsigned PW = idx_width(SLOTS);

    arb_state_t state_q, state_d;

    logic [AW-1:0]    tag_q  [SLOTS];
    logic [DW-1:0]    data_q [SLOTS];
    logic [SLOTS-1:0] valid_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    gnt_q;

    logic [AW-1:0]    addr_a [SLOTS];
    logic [SLOTS-1:0] hit;
    logic [SLOTS-1:0] pend;
    logic [PW-1:0]    pick_gnt;
    logic             pick_any;

    logic             grant_en;
    logic             ack_en;
    logic             fill_en;

    // Cache lookup against registered tags; outputs follow the requester address.
    always_comb begin
        for (int i = 0; i < SLOTS; i++) begin
            addr_a[i]             = slot_addr[i*AW +: AW];
            hit[i]                = valid_q[i] && (tag_q[i] == addr_a[i]);
            slot_ok[i]            = slot_cs[i] && hit[i] && !downloading;
            pend[i]               = slot_cs[i] && !hit[i] && !downloading;
            slot_dout[i*DW +: DW] = data_q[i];
        end
    end

    jtdd_rr_pick #(
        .SLOTS (SLOTS),
        .PW    (PW)
    ) u_pick (
        .pend (pend),
        .ptr  (ptr_q),
        .gnt  (pick_gnt),
        .any  (pick_any)
    );

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Downloading overrides everything and parks the FSM in IDLE.
    always_comb begin
        state_d = state_q;
        if (downloading) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (pick_any) state_d = REQ;
                REQ:  if (sdram_ack) state_d = data_rdy ? IDLE : WAIT;
                WAIT: if (data_rdy) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // An ack arriving together with rdy completes the transaction in REQ.
    always_comb begin
        grant_en = 1'b0;
        ack_en   = 1'b0;
        fill_en  = 1'b0;
        if (!downloading) begin
            case (state_q)
                IDLE: grant_en = pick_any;
                REQ: begin
                    ack_en  = sdram_ack;
                    fill_en = sdram_ack && data_rdy;
                end
                WAIT: fill_en = data_rdy;
                default: ;
            endcase
        end
    end

    // Request/handshake registers and the per-slot cache.
    always_ff @(posedge clk) begin
        if (!rstb) begin
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            busy       <= 1'b0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            valid_q    <= '0;
            for (int i = 0; i < SLOTS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (downloading) begin
            sdram_req <= 1'b0;
            busy      <= 1'b0;
            valid_q   <= '0;
        end else begin
            if (grant_en) begin
                gnt_q      <= pick_gnt;
                sdram_addr <= addr_a[pick_gnt];
                sdram_req  <= 1'b1;
                busy       <= 1'b1;
                if (32'(pick_gnt) == SLOTS - 1) begin
                    ptr_q <= '0;
                end else begin
                    ptr_q <= pick_gnt + PW'(1);
                end
            end
            if (ack_en) begin
                sdram_req <= 1'b0;
            end
            if (fill_en) begin
                data_q[gnt_q]  <= data_read;
                tag_q[gnt_q]   <= sdram_addr;
                valid_q[gnt_q] <= 1'b1;
                busy           <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_jtdd_sdram_arb.sv
// Directed bench for jtdd_sdram_arb with a hand-driven SDRAM controller.
`timescale 1ns/1ps
module tb_jtdd_sdram_arb;

    localparam int unsigned SLOTS = 4;
    localparam int unsigned AW    = 22;
    localparam int unsigned DW    = 32;

    logic                clk = 1'b0;
    logic                rstb;
    logic                downloading;
    logic [SLOTS-1:0]    slot_cs;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*DW-1:0] slot_dout;
    logic                sdram_req;
    logic [AW-1:0]       sdram_addr;
    logic                sdram_ack;
    logic                data_rdy;
    logic [DW-1:0]       data_read;
    logic                busy;

    int n_assert = 0;
    int n_fail   = 0;

    jtdd_sdram_arb #(
        .SLOTS (SLOTS),
        .AW    (AW),
        .DW    (DW)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .downloading (downloading),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300us;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int i, input logic [AW-1:0] a);
        slot_addr[i*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] dout_of(input int i);
        return slot_dout[i*DW +: DW];
    endfunction

    // Serve one transaction: ack after ack_wait held cycles, rdy rdy_wait cycles after ack.
    task automatic serve(input int ack_wait, input int rdy_wait,
                         input logic [DW-1:0] d, output logic [AW-1:0] a);
        int n;
        n = 0;
        while (sdram_req !== 1'b1 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("req_seen", 64'(sdram_req), 64'(1));
        a = sdram_addr;
        for (int k = 0; k < ack_wait; k++) begin
            @(negedge clk); #1;
            chk("addr_hold", 64'({sdram_req, sdram_addr}), 64'({1'b1, a}));
        end
        chk("busy_req", 64'(busy), 64'(1));
        sdram_ack = 1'b1;
        if (rdy_wait == 0) begin
            data_rdy  = 1'b1;
            data_read = d;
        end
        @(negedge clk);
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        if (rdy_wait > 0) begin
            for (int k = 1; k < rdy_wait; k++) @(negedge clk);
            chk("busy_wait", 64'(busy), 64'(1));
            data_rdy  = 1'b1;
            data_read = d;
            @(negedge clk);
            data_rdy = 1'b0;
        end
        #1;
    endtask

    initial begin
        logic [AW-1:0] a;

        rstb        = 1'b0;
        downloading = 1'b0;
        sdram_ack   = 1'b0;
        data_rdy    = 1'b0;
        data_read   = '0;
        slot_cs     = 4'hF;
        slot_addr   = '0;
        for (int i = 0; i < SLOTS; i++) set_addr(i, AW'(32'h10 * (i + 1)));

        // Reset held for 4 cycles with every slot selected.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            chk("rst_req", 64'(sdram_req), 64'(0));
            chk("rst_ok", 64'(slot_ok), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
        end
        chk("rst_dout", 64'(|slot_dout), 64'(0));
        rstb = 1'b1;
        @(negedge clk); #1;
        chk("first_req", 64'({sdram_req, sdram_addr}), 64'({1'b1, 22'h10}));

        // Round-robin, first pass: slots 0..3 in order.
        for (int i = 0; i < SLOTS; i++) begin
            serve(0, 0, 32'hA000_0000 | DW'(i), a);
            chk("rr1_addr", 64'(a), 64'(32'h10 * (i + 1)));
        end
        chk("rr1_ok", 64'(slot_ok), 64'(4'hF));

        // Re-trigger all misses at once: pointer wrapped back to slot 0.
        set_addr(0, 22'h50);
        set_addr(1, 22'h60);
        set_addr(2, 22'h70);
        set_addr(3, 22'h80);
        for (int i = 0; i < SLOTS; i++) begin
            serve(0, 1, 32'hB000_0000 | DW'(i), a);
            chk("rr2_addr", 64'(a), 64'(32'h50 + 32'h10 * i));
        end
        chk("rr2_ok", 64'(slot_ok), 64'(4'hF));
        chk("rr2_dout0", 64'(dout_of(0)), 64'(32'hB000_0000));
        chk("rr2_dout3", 64'(dout_of(3)), 64'(32'hB000_0003));

        // Single miss on slot 2: ack after 2 cycles, data 5 cycles later.
        slot_cs = 4'b0100;
        set_addr(2, 22'h2_8004);
        #1;
        chk("sm_miss_ok", 64'(slot_ok), 64'(0));
        serve(2, 5, 32'hDEAD_BEEF, a);
        chk("sm_addr", 64'(a), 64'(22'h2_8004));
        chk("sm_ok", 64'(slot_ok), 64'(4'b0100));
        chk("sm_dout", 64'(dout_of(2)), 64'(32'hDEAD_BEEF));
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            chk("sm_no_rereq", 64'({sdram_req, slot_ok}), 64'({1'b0, 4'b0100}));
        end

        // Address change while the fetch is in WAIT.
        slot_cs = 4'b0010;
        set_addr(1, 22'h100);
        @(negedge clk); #1;
        chk("ac_req", 64'({sdram_req, sdram_addr}), 64'({1'b1, 22'h100}));
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack = 1'b0;
        set_addr(1, 22'h104);
        #1;
        chk("ac_wait", 64'({busy, sdram_req}), 64'({1'b1, 1'b0}));
        @(negedge clk);
        data_rdy  = 1'b1;
        data_read = 32'h1111_1111;
        @(negedge clk);
        data_rdy = 1'b0;
        #1;
        chk("ac_ok_low", 64'(slot_ok), 64'(0));
        chk("ac_old_data", 64'(dout_of(1)), 64'(32'h1111_1111));
        serve(0, 1, 32'h2222_2222, a);
        chk("ac_new_addr", 64'(a), 64'(22'h104));
        chk("ac_ok", 64'(slot_ok), 64'(4'b0010));
        chk("ac_dout", 64'(dout_of(1)), 64'(32'h2222_2222));

        // Download abort with slot 3 in WAIT; slots 0 and 1 were hitting.
        slot_cs = 4'b1011;
        set_addr(3, 22'h333);
        #1;
        chk("dl_pre_ok", 64'(slot_ok), 64'(4'b0011));
        @(negedge clk); #1;
        chk("dl_req", 64'({sdram_req, sdram_addr}), 64'({1'b1, 22'h333}));
        sdram_ack = 1'b1;
        @(negedge clk);
        sdram_ack   = 1'b0;
        downloading = 1'b1;
        @(negedge clk); #1;
        chk("dl_quiet", 64'({sdram_req, busy, slot_ok}), 64'(0));
        data_rdy  = 1'b1;
        data_read = 32'hBAD0_BAD0;
        @(negedge clk);
        data_rdy    = 1'b0;
        downloading = 1'b0;
        #1;
        chk("dl_all_miss", 64'(slot_ok), 64'(0));
        serve(0, 0, 32'hC000_0000, a);
        chk("dl_refetch0", 64'(a), 64'(22'h50));
        serve(0, 0, 32'hC000_0001, a);
        chk("dl_refetch1", 64'(a), 64'(22'h104));
        serve(0, 0, 32'hC000_0003, a);
        chk("dl_refetch3", 64'(a), 64'(22'h333));
        chk("dl_ok", 64'(slot_ok), 64'(4'b1011));
        chk("dl_dout3", 64'(dout_of(3)), 64'(32'hC000_0003));

        // Ack and rdy together on the first REQ cycle, then a back-to-back grant.
        slot_cs = 4'b0100;
        set_addr(2, 22'h444);
        @(negedge clk); #1;
        chk("ar_req", 64'({sdram_req, sdram_addr}), 64'({1'b1, 22'h444}));
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        data_read = 32'h5A5A_5A5A;
        @(negedge clk);
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        set_addr(2, 22'h448);
        #1;
        chk("ar_fill", 64'({busy, sdram_req, dout_of(2)}), 64'({2'b00, 32'h5A5A_5A5A}));
        @(negedge clk); #1;
        chk("ar_next_req", 64'({sdram_req, sdram_addr}), 64'({1'b1, 22'h448}));
        serve(0, 1, 32'h0BAD_F00D, a);
        chk("ar_ok", 64'({slot_ok, dout_of(2)}), 64'({4'b0100, 32'h0BAD_F00D}));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jtdd_sdram_arb.md
Name: jtdd_sdram_arb

Overview:
- Shares the single SDRAM read port between N ROM requesters: main CPU, sound CPU, MCU, ADPCM and the graphics fetchers.
- Each slot owns a one-word cache: a tag plus a 32-bit data register.
- A cache miss raises a pending request. A round-robin scheduler sequences one SDRAM transaction at a time through a req/ack/rdy handshake.
- Sits between the game-level slot wiring and the SDRAM controller. Data-width selection and slot offsets are applied by the caller.

Parameters:
- SLOTS, 4: number of requesters (1..8).
- AW, 22: SDRAM word address width.
- DW, 32: SDRAM data width.

Ports:
- clk  in  1  system clock (48 MHz)
- rstb  in  1  synchronous active-low reset
- downloading  in  1  ROM download in progress; blocks all reads
- slot_cs  in  SLOTS  per-slot read enable
- slot_addr  in  SLOTS*AW  packed per-slot absolute SDRAM address; slot i at [i*AW +: AW]
- slot_ok  out  SLOTS  slot data valid for the current address
- slot_dout  out  SLOTS*DW  packed per-slot cached word
- sdram_req  out  1  request to SDRAM controller
- sdram_addr  out  AW  address of the granted request
- sdram_ack  in  1  controller accepted the request
- data_rdy  in  1  data_read valid for the accepted request
- data_read  in  DW  SDRAM read data
- busy  out  1  transaction in flight; debug only

Behaviour:
- Reset (rstb=0 at a clk edge) clears everything: all tags, valid bits and data registers to 0; sdram_req=0, sdram_addr=0, busy=0; round-robin pointer=0; FSM to IDLE. Reset mid-transaction abandons it, and any late data_rdy is ignored.
- Hit (combinational, from registered state): hit[i] = valid[i] && tag[i]==slot_addr[i]. slot_ok[i] = slot_cs[i] && hit[i] && !downloading. slot_dout[i] is always the data register, gated by nothing.
- Pending: pend[i] = slot_cs[i] && !hit[i] && !downloading.
- FSM state IDLE:
  - If any pend bit is set, grant the first pending slot searching from ptr, ptr+1, ... modulo SLOTS.
  - Latch gnt index and sdram_addr=slot_addr[gnt]. Set sdram_req=1, busy=1, go to REQ.
  - Set ptr = gnt+1 modulo SLOTS, so the granted slot gets the lowest priority next time.
- FSM state REQ: hold sdram_req and sdram_addr stable until sdram_ack=1. On ack, drop sdram_req the next cycle and go to WAIT.
- FSM state WAIT:
  - On data_rdy: data[gnt] <= data_read, tag[gnt] <= latched sdram_addr, valid[gnt] <= 1, busy=0, go to IDLE.
  - The earliest slot_ok rise is the cycle after data_rdy.
- ack and rdy in the same cycle (REQ state): treat as complete. Store the data and go straight to IDLE.
- Requester changes address mid-transaction: the fetch still completes and fills the cache with the old tag. slot_ok stays low because the tag mismatches. The slot re-requests in a later IDLE.
- slot_cs dropped mid-transaction: the transaction completes and fills the cache normally.
- Back-to-back grants: IDLE lasts exactly one cycle when any pend bit is set. Minimum cost is 3 cycles per transaction (IDLE, REQ with immediate ack, WAIT with rdy).
- downloading=1:
  - Clears all valid bits every cycle and forces sdram_req=0 and the FSM to IDLE.
  - No new grants are issued.
  - An outstanding data_rdy is discarded.
  - On its falling edge, all slots miss and refetch.
- Minimum latency from miss to slot_ok: 3 cycles, given immediate ack and rdy.
- Fairness: with all SLOTS pending, each slot is served exactly once per SLOTS transactions.

Decomposition:
- Package jtdd_sdram_arb_pkg holds:
  - typedef of the FSM state enum {IDLE, REQ, WAIT};
  - localparam for the AW/DW defaults.
- Sub-module jtdd_rr_pick: a combinational round-robin picker. Inputs are pend[SLOTS] and ptr; outputs are gnt index and any.
- The per-slot cache registers remain in the top-level module.

Test Plan:
- Reset: hold rstb=0 for 4 cycles with slot_cs=4'hF. Required response: sdram_req=0, slot_ok=0, busy=0 throughout; the first request appears 1 cycle after rstb=1.
- Single miss: slot 2, addr 22'h2_8004; controller acks after 2 cycles and returns data 32'hDEADBEEF 5 cycles later. Required response:
  - sdram_addr=22'h2_8004, held stable until ack;
  - slot_ok[2]=1 the cycle after rdy, with slot_dout[2]=DEADBEEF;
  - a second access to the same address raises no new sdram_req.
- Round-robin: all 4 slots miss simultaneously with distinct addresses. Required response: grant order 0,1,2,3; re-triggered misses are then served in order 0,1,2,3 again; no slot waits more than 4 transactions.
- Address change mid-fetch: slot 1 moves from 22'h100 to 22'h104 while in WAIT. Required response: slot_ok[1] stays 0 after rdy, and a new request for 22'h104 is issued.
- Download abort: downloading asserted in WAIT, then rdy arrives. Required response: no cache fill, slot_ok=0; after downloading falls, the previously hit slots refetch.
- Simultaneous ack and rdy on the first REQ cycle. Required response: data captured and the FSM back in IDLE the next cycle; 3-cycle turnaround.
